ex_alu_md: RTL and testbench

- Parametrised successor to the single-cycle execute ALU in the MIPS core's EX stage.
- Widens the op set to 4-bit ALUOp: logic, compare and shift ops, plus an iterative unsigned multiply/divide unit with HI/LO registers.
- Results are registered, with a valid/ready handshake on input and a valid pulse on output.
- Sits between ID/EX operand latching and the EX/MEM register; the pipeline stalls on in_ready=0.

---
 rtl/ex_alu_md_if.sv | 29 ++
 rtl/ex_alu_md.sv | 157 +++++++++++++++
 tb/tb_ex_alu_md.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_md_if.sv
// Handshake and operand/result bundle for the EX-stage ALU with multiply/divide.
interface ex_alu_md_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic [WIDTH-1:0] imm32;
  logic             BSel;
  logic             out_valid;
  logic [WIDTH-1:0] ALUout;
  logic             ovf;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Upstream pipeline stage: presents ops, observes results
  modport master (
    output in_valid, ALUOp, rdata1, rdata2, imm32, BSel,
    input  in_ready, out_valid, ALUout, ovf, hi, lo
  );

  // The ALU itself
  modport slave (
    input  in_valid, ALUOp, rdata1, rdata2, imm32, BSel,
    output in_ready, out_valid, ALUout, ovf, hi, lo
  );
endinterface

// File: rtl/ex_alu_md.sv
// EX-stage ALU: single-cycle logic/compare/shift ops with registered result,
// plus an iterative unsigned multiply/divide unit feeding HI/LO.
module ex_alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst,
  ex_alu_md_if.slave bus
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hw;   // MUL: product upper half; DIV: partial remainder
  logic [WIDTH-1:0] r_lw;   // MUL: product lower half / multiplier; DIV: dividend -> quotient
  logic [WIDTH-1:0] r_opb;  // MUL: multiplicand; DIV: divisor
  logic [WIDTH-1:0] r_alu;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_ovf;
  logic             r_vld;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_rsub;
  logic             w_nb;

  assign w_a      = bus.rdata1;
  assign w_b      = bus.BSel ? bus.imm32 : bus.rdata2;
  assign w_shamt  = w_b[SHW-1:0];
  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_sum    = w_a + w_b;

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole product right.
  assign w_madd = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

  // One restoring-division step: bring in the next dividend bit and
  // subtract the divisor if it fits (no borrow out of the top bit).
  assign w_rsh  = {r_hw, r_lw[WIDTH-1]};
  assign w_rsub = w_rsh - {1'b0, r_opb};
  assign w_nb   = ~w_rsub[WIDTH];

  // Single-cycle result and signed-overflow flag for the current op
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.ALUOp)
      4'd0:  w_res = w_sum;
      4'd1:  w_res = w_a - w_b;
      4'd2:  w_res = w_a | w_b;
      4'd3: begin
        w_res = w_sum;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      4'd4:  w_res = w_a & w_b;
      4'd5:  w_res = w_a ^ w_b;
      4'd6:  w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'd7:  w_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      4'd8:  w_res = w_a << w_shamt;
      4'd9:  w_res = w_a >> w_shamt;
      4'd10: w_res = $unsigned($signed(w_a) >>> w_shamt);
      4'd13: w_res = r_hi;
      4'd14: w_res = r_lo;
      default: w_res = '0;
    endcase
  end

  // Control FSM, iterative datapath and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hw    <= '0;
      r_lw    <= '0;
      r_opb   <= '0;
      r_alu   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ovf   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.ALUOp == 4'd11) begin
              r_state <= MUL;
              r_cnt   <= CW'(WIDTH);
              r_hw    <= '0;
              r_lw    <= w_b;
              r_opb   <= w_a;
            end else if (bus.ALUOp == 4'd12) begin
              if (w_b == '0) begin
                // Divide by zero completes immediately with a defined result
                r_hi  <= w_a;
                r_lo  <= '1;
                r_alu <= '1;
                r_ovf <= 1'b0;
                r_vld <= 1'b1;
              end else begin
                r_state <= DIV;
                r_cnt   <= CW'(WIDTH);
                r_hw    <= '0;
                r_lw    <= w_a;
                r_opb   <= w_b;
              end
            end else begin
              r_alu <= w_res;
              r_ovf <= w_ovf;
              r_vld <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_state == MUL) begin
              r_hw <= w_madd[WIDTH:1];
              r_lw <= {w_madd[0], r_lw[WIDTH-1:1]};
            end else begin
              r_hw <= w_nb ? w_rsub[WIDTH-1:0] : w_rsh[WIDTH-1:0];
              r_lw <= {r_lw[WIDTH-2:0], w_nb};
            end
          end else begin
            r_hi    <= r_hw;
            r_lo    <= r_lw;
            r_alu   <= r_lw;
            r_ovf   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_vld;
  assign bus.ALUout    = r_alu;
  assign bus.ovf       = r_ovf;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

// File: tb/tb_ex_alu_md.sv
// Scoreboard bench for ex_alu_md: the driver pushes model results when an op
// is accepted, an independent monitor pops and compares on every out_valid.
module tb_ex_alu_md;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    int           op;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;

  ex_alu_md_if #(.WIDTH(W)) bus ();

  ex_alu_md #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the op definitions
  function automatic exp_t model(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    longint s;
    logic [2*W-1:0] p;
    int sh;
    sh = int'(b % W);
    e.ovf = 1'b0;
    e.res = '0;
    e.op  = op;
    e.cyc = acc;
    case (op)
      0:  e.res = a + b;
      1:  e.res = a - b;
      2:  e.res = a | b;
      3: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = a + b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4:  e.res = a & b;
      5:  e.res = a ^ b;
      6:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      7:  e.res = (a < b) ? 1 : 0;
      8:  e.res = a << sh;
      9:  e.res = a >> sh;
      10: e.res = $unsigned($signed(a) >>> sh);
      11: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        ref_hi = p[2*W-1:W];
        ref_lo = p[W-1:0];
        e.res = ref_lo;
        e.cyc = acc + W + 1;
      end
      12: begin
        if (b == 0) begin
          ref_hi = a;
          ref_lo = '1;
        end else begin
          ref_hi = a % b;
          ref_lo = a / b;
          e.cyc = acc + W + 1;
        end
        e.res = ref_lo;
      end
      13: e.res = ref_hi;
      14: e.res = ref_lo;
      default: e.res = '0;
    endcase
    e.hi = ref_hi;
    e.lo = ref_lo;
    return e;
  endfunction

  // Present an op at a negedge, hold it until accepted, then drop in_valid
  task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input bit bsel);
    int n;
    bus.in_valid = 1'b1;
    bus.ALUOp    = 4'(op);
    bus.rdata1   = a;
    bus.BSel     = bsel;
    if (bsel) begin
      bus.imm32  = b;
      bus.rdata2 = $urandom;
    end else begin
      bus.rdata2 = b;
      bus.imm32  = $urandom;
    end
    n = 0;
    while (!bus.in_ready && n <= 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      q.push_back(model(op, a, b, cyc + 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every result pulse must match the oldest outstanding op
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        $display("op=%0d ALUout=%h ovf=%0d hi=%h lo=%h cyc=%0d", e.op, bus.ALUout, bus.ovf, bus.hi, bus.lo, cyc);
        chk("ALUout", bus.ALUout, e.res);
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.ALUOp    = '0;
    bus.rdata1   = '0;
    bus.rdata2   = '0;
    bus.imm32    = '0;
    bus.BSel     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ALUout", bus.ALUout, '0);
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed single-cycle cases
    issue(0, 32'd5, 32'd7, 1'b1);
    issue(3, 32'h7FFFFFFF, 32'd1, 1'b0);
    issue(0, 32'h7FFFFFFF, 32'd1, 1'b0);
    issue(6, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(7, 32'hFFFFFFFF, 32'd1, 1'b0);
    issue(10, 32'h80000000, 32'd4, 1'b1);
    issue(15, 32'h12345678, 32'h9, 1'b0);

    // Multiply, busy flag, then read-back of HI/LO
    issue(11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    issue(13, 32'd0, 32'd0, 1'b0);
    issue(14, 32'd0, 32'd0, 1'b0);

    // Divide, divide-by-zero, DIV with a held ADDU behind it
    issue(12, 32'd100, 32'd7, 1'b0);
    issue(12, 32'd9, 32'd0, 1'b0);
    issue(13, 32'd0, 32'd0, 1'b0);
    issue(12, 32'hDEADBEEF, 32'd3, 1'b1);
    issue(0, 32'd1, 32'd2, 1'b0);

    // Reset part-way through a multiply
    issue(11, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q.delete();
    ref_hi = '0;
    ref_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_hi", bus.hi, '0);
    chk("midrst_lo", bus.lo, '0);
    issue(2, 32'hF0, 32'h0F, 1'b1);
    issue(14, 32'd0, 32'd0, 1'b0);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 10; i++) begin
      issue($urandom_range(0, 10), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Randomised mix including multiply/divide and idle gaps
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = $urandom_range(0, 15);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 40));
        1: b = 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      issue(op, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
